// File: rtl/jac_pkg.sv
// Shared types and constants for the fetch/decode front end.
// Holds the fetch FSM state type, default widths and opcode constants.
package jac_pkg;

   localparam int unsigned PcWidthDefault          = 8;
   localparam int unsigned ProgramDataWidthDefault = 16;
   localparam int unsigned ParamBitsDefault        = 8;

   // An all-zero instruction word decodes as a no-op.
   localparam logic [ProgramDataWidthDefault-1:0] Op_NOP = '0;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StExec
   } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-pc selection: pc+1, absolute jump or relative jump.
// FETCH_SIGNED_OFFSET_EN selects a sign-extended offset; otherwise it is zero-extended.
module pc_next #(
   parameter int unsigned PC_WIDTH  = 8,
   parameter int unsigned ParamBits = 8
) (
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 cnt_wr_en,
   input  logic                 add_offset,
   input  logic [PC_WIDTH-1:0]  literal_adr,
   input  logic [ParamBits-1:0] offset,
   output logic [PC_WIDTH-1:0]  next_pc
);

   logic [PC_WIDTH-1:0] offset_ext;

`ifdef FETCH_SIGNED_OFFSET_EN
   assign offset_ext = PC_WIDTH'($signed(offset));
`else
   assign offset_ext = PC_WIDTH'(offset);
`endif

   // Sums are truncated to PC_WIDTH, so all pc arithmetic wraps.
   always_comb begin
      next_pc = pc + PC_WIDTH'(1);
      if (cnt_wr_en) begin
         if (add_offset) begin
            next_pc = pc + offset_ext;
         end else begin
            next_pc = literal_adr;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word at pc, loads the instruction register,
// then waits for the execute stage before advancing pc.
module fetch_unit
   import jac_pkg::*;
#(
   parameter int unsigned PC_WIDTH          = PcWidthDefault,
   parameter int unsigned PROGRAM_DataWidth = ProgramDataWidthDefault,
   parameter int unsigned ParamBits         = ParamBitsDefault
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   output logic                         mem_req,
   output logic [PC_WIDTH-1:0]          mem_adr,
   input  logic                         mem_ack,
   input  logic [PROGRAM_DataWidth-1:0] mem_data,
   output logic [PROGRAM_DataWidth-1:0] instruction,
   output logic                         instr_valid,
   input  logic                         exec_done,
   input  logic                         cnt_wr_en,
   input  logic                         add_offset,
   input  logic [PC_WIDTH-1:0]          literal_adr,
   input  logic [ParamBits-1:0]         offset,
   output logic [PC_WIDTH-1:0]          pc,
   output logic                         busy
);

   fetch_state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]          pc_q, pc_d;
   logic [PROGRAM_DataWidth-1:0] instr_q, instr_d;
   logic                         valid_q, valid_d;
   logic [PC_WIDTH-1:0]          next_pc;

   pc_next #(
      .PC_WIDTH  (PC_WIDTH),
      .ParamBits (ParamBits)
   ) u_pc_next (
      .pc          (pc_q),
      .cnt_wr_en   (cnt_wr_en),
      .add_offset  (add_offset),
      .literal_adr (literal_adr),
      .offset      (offset),
      .next_pc     (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         instr_q <= PROGRAM_DataWidth'(Op_NOP);
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // mem_ack is only honoured in StReq and exec_done only in StExec.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) state_d = StReq;
         end
         StReq: begin
            if (mem_ack) begin
               instr_d = mem_data;
               valid_d = 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            if (exec_done) begin
               pc_d    = next_pc;
               state_d = run ? StReq : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs come straight from registers so reset clears them without a clock.
   assign mem_req     = (state_q == StReq);
   assign mem_adr     = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of fetch/execute steps plus
// hand-written sequences for run drop, ignored inputs and asynchronous reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        mem_req;
   logic [7:0]  mem_adr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        exec_done;
   logic        cnt_wr_en;
   logic        add_offset;
   logic [7:0]  literal_adr;
   logic [7:0]  offset;
   logic [7:0]  pc;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acks   = 0;
   int n_pulses = 0;

   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .mem_req     (mem_req),
      .mem_adr     (mem_adr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .cnt_wr_en   (cnt_wr_en),
      .add_offset  (add_offset),
      .literal_adr (literal_adr),
      .offset      (offset),
      .pc          (pc),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every instr_valid pulse must match the oldest acknowledged word.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_instr_valid", 32'(instr_valid), 32'(1'b0));
         end else begin
            check("instruction_on_valid", 32'(instruction), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [7:0] exp_adr, input logic [15:0] data, input int waits);
      int guard = 0;
      while (mem_req !== 1'b1 && guard < 10) begin
         tick();
         guard++;
      end
      check("mem_req_seen", 32'(mem_req), 32'(1'b1));
      check("mem_adr", 32'(mem_adr), 32'(exp_adr));
      for (int w = 0; w < waits; w++) begin
         tick();
         check("mem_req_held", 32'(mem_req), 32'(1'b1));
         check("mem_adr_held", 32'(mem_adr), 32'(exp_adr));
      end
      mem_ack  = 1'b1;
      mem_data = data;
      exp_q.push_back(data);
      n_acks++;
      tick();
      mem_ack  = 1'b0;
      mem_data = 16'(~data);
      check("mem_req_drop_after_ack", 32'(mem_req), 32'(1'b0));
   endtask

   task automatic execute(input logic cw, input logic ao, input logic [7:0] lit,
                          input logic [7:0] off, input logic [7:0] start_pc,
                          input logic [15:0] data, input logic [7:0] exp_pc);
      // One idle EXEC cycle: instruction must stay put and pc must not move.
      tick();
      check("instr_stable_exec", 32'(instruction), 32'(data));
      check("valid_single_pulse", 32'(instr_valid), 32'(1'b0));
      check("pc_before_exec_done", 32'(pc), 32'(start_pc));
      exec_done   = 1'b1;
      cnt_wr_en   = cw;
      add_offset  = ao;
      literal_adr = lit;
      offset      = off;
      tick();
      exec_done   = 1'b0;
      cnt_wr_en   = 1'b0;
      add_offset  = 1'b0;
      check("pc_after_exec_done", 32'(pc), 32'(exp_pc));
   endtask

   typedef struct {
      logic        cw;
      logic        ao;
      logic [7:0]  lit;
      logic [7:0]  off;
      logic [15:0] data;
      int          waits;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [7:0] cur_pc;

      vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0A05, 0, 8'h01};
      vecs[1] = '{1'b1, 1'b0, 8'h3F, 8'h00, 16'h1111, 1, 8'h3F};
      vecs[2] = '{1'b0, 1'b1, 8'hAA, 8'h55, 16'h2222, 0, 8'h40};
      vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 16'h3333, 2, 8'h10};
      vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h09, 16'h4444, 0, 8'h19};
      // 8-bit pc and offset: -2 and +254 land on the same address.
      vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFE, 16'h5555, 1, 8'h17};
      vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 16'h6666, 0, 8'hFF};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h7777, 0, 8'h00};
      vecs[8] = '{1'b1, 1'b1, 8'h00, 8'h80, 16'h8888, 0, 8'h80};

      rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
      exec_done = 1'b0; cnt_wr_en = 1'b0; add_offset = 1'b0;
      literal_adr = 8'h0; offset = 8'h0;
      #1;
      check("rst_mem_req", 32'(mem_req), 32'(1'b0));
      check("rst_pc", 32'(pc), 32'(8'h00));
      check("rst_instruction", 32'(instruction), 32'(16'h0000));
      check("rst_instr_valid", 32'(instr_valid), 32'(1'b0));
      check("rst_busy", 32'(busy), 32'(1'b0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_no_req", 32'(mem_req), 32'(1'b0));
      run = 1'b1;
      tick();
      check("req_after_run", 32'(mem_req), 32'(1'b1));
      check("busy_in_req", 32'(busy), 32'(1'b1));

      cur_pc = 8'h00;
      for (int i = 0; i < 9; i++) begin
         fetch(cur_pc, vecs[i].data, vecs[i].waits);
         execute(vecs[i].cw, vecs[i].ao, vecs[i].lit, vecs[i].off, cur_pc,
                 vecs[i].data, vecs[i].exp_pc);
         check("busy_after_exec_run", 32'(busy), 32'(1'b1));
         cur_pc = vecs[i].exp_pc;
      end

      // run dropped while a request is outstanding.
      run = 1'b0;
      fetch(8'h80, 16'h9ABC, 3);
      execute(1'b0, 1'b0, 8'h00, 8'h00, 8'h80, 16'h9ABC, 8'h81);
      check("busy_after_run_drop", 32'(busy), 32'(1'b0));
      check("req_after_run_drop", 32'(mem_req), 32'(1'b0));
      tick();
      check("stays_idle", 32'(busy), 32'(1'b0));

      // mem_ack and exec_done are ignored in IDLE.
      mem_ack = 1'b1; mem_data = 16'hDEAD;
      exec_done = 1'b1; cnt_wr_en = 1'b1; literal_adr = 8'h55;
      tick();
      mem_ack = 1'b0; exec_done = 1'b0; cnt_wr_en = 1'b0;
      check("ignored_pc", 32'(pc), 32'(8'h81));
      check("ignored_busy", 32'(busy), 32'(1'b0));
      check("ignored_instruction", 32'(instruction), 32'(16'h9ABC));

      // Asynchronous reset in the middle of a request.
      run = 1'b1;
      tick();
      check("req_before_rst", 32'(mem_req), 32'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_mem_req", 32'(mem_req), 32'(1'b0));
      check("async_rst_pc", 32'(pc), 32'(8'h00));
      check("async_rst_instruction", 32'(instruction), 32'(16'h0000));
      check("async_rst_busy", 32'(busy), 32'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      fetch(8'h00, 16'h0C0D, 0);
      execute(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0C0D, 8'h01);
      run = 1'b0;
      tick();
      tick();

      check("valid_pulse_count", 32'(n_pulses), 32'(n_acks));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
